// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: snapshots a flat register file and streams
// (index, value) pairs over valid/ready, either in full or changed-only.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   regfile_flat      register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   start, diff_mode  dump request (IDLE only) and its mode (1 = diff)
//   out_valid/ready   entry handshake; out_idx/out_data carry the entry
//   busy, done        busy in SCAN/DONE, one-cycle done pulse at the end
//   emit_count        entries emitted by the last completed dump
module regfile_dump_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int SKIP_ZERO  = 1,
    parameter int IDX_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regfile_flat,
    input  logic                           start,
    input  logic                           diff_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_WIDTH-1:0]           out_idx,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           busy,
    output logic                           done,
    output logic [IDX_WIDTH:0]             emit_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LP_FIRST =
        (SKIP_ZERO != 0) ? IDX_WIDTH'(1) : '0;
    localparam logic [IDX_WIDTH-1:0] LP_LAST =
        IDX_WIDTH'(NUM_REGS - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_snap [NUM_REGS];
    logic [DATA_WIDTH-1:0]   r_prev [NUM_REGS];
    logic                    r_mode;
    logic [IDX_WIDTH-1:0]    r_ptr;
    logic [IDX_WIDTH:0]      r_cnt;
    logic [IDX_WIDTH:0]      r_emit_count;

    logic                    w_start_ok;
    logic                    w_elig;
    logic                    w_fire;
    logic                    w_step;
    logic                    w_last;

    // Full dump emits every entry; diff dump only entries that changed
    // between the previous snapshot and this one.
    assign w_elig     = !r_mode || (r_snap[r_ptr] != r_prev[r_ptr]);
    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_fire     = out_valid && out_ready;
    // An ineligible entry is skipped in one cycle; an eligible entry
    // is held until the consumer takes it.
    assign w_step     = (r_state == S_SCAN) && (!w_elig || out_ready);
    assign w_last     = (r_ptr == LP_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_step && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                out_valid = 1'b0;
            end
            S_SCAN: begin
                out_valid = w_elig;
                busy      = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_idx    = r_ptr;
    assign out_data   = r_snap[r_ptr];
    assign emit_count = r_emit_count;

    // Snapshot storage, scan pointer and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_snap[i] <= '0;
                r_prev[i] <= '0;
            end
            r_mode       <= 1'b0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_emit_count <= '0;
        end else begin
            if (w_start_ok) begin
                // Old snapshot becomes the diff reference.
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_prev[i] <= r_snap[i];
                    r_snap[i] <= regfile_flat[i*DATA_WIDTH +: DATA_WIDTH];
                end
                r_mode <= diff_mode;
                r_ptr  <= LP_FIRST;
                r_cnt  <= '0;
            end
            if (w_fire) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_step && !w_last) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (r_state == S_DONE) begin
                r_emit_count <= r_cnt;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb_regfile_dump_unit: directed checks of regfile_dump_unit with the
// default build and a small 8 x 16-bit build without x0 skipping.
module tb_regfile_dump_unit;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int IW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR*DW-1:0]  rf;
    logic              start;
    logic              diff_mode;
    logic              out_ready;
    logic              out_valid;
    logic [IW-1:0]     out_idx;
    logic [DW-1:0]     out_data;
    logic              busy;
    logic              done;
    logic [IW:0]       emit_count;

    logic [8*16-1:0]   rf8;
    logic              start8;
    logic              diff8;
    logic              ready8;
    logic              valid8;
    logic [2:0]        idx8;
    logic [15:0]       data8;
    logic              busy8;
    logic              done8;
    logic [3:0]        ec8;

    regfile_dump_unit u_dut (
        .clk          (clk),
        .rst          (rst),
        .regfile_flat (rf),
        .start        (start),
        .diff_mode    (diff_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done),
        .emit_count   (emit_count)
    );

    regfile_dump_unit #(
        .DATA_WIDTH (16),
        .NUM_REGS   (8),
        .SKIP_ZERO  (0)
    ) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .regfile_flat (rf8),
        .start        (start8),
        .diff_mode    (diff8),
        .out_valid    (valid8),
        .out_ready    (ready8),
        .out_idx      (idx8),
        .out_data     (data8),
        .busy         (busy8),
        .done         (done8),
        .emit_count   (ec8)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] m_snap [NR];
    logic [DW-1:0] m_prev [NR];
    int            got_idx [$];
    logic [DW-1:0] got_dat [$];
    int            n_done;
    int            n_busy_post;
    int            lat;
    logic [IW:0]   ec_after;
    bit            m_diff;

    function automatic void set_reg(int i, logic [DW-1:0] v);
        rf[i*DW +: DW] = v;
    endfunction

    // bp: ready pattern 1-0-0-1; abort_n: reset after that many
    // transfers; mid: restart attempt and regfile change mid-scan.
    task automatic run_dump(input bit diff, input bit bp,
                            input int abort_n, input bit mid);
        logic             pv;
        logic             pr;
        logic [IW-1:0]    pidx;
        logic [DW-1:0]    pdat;
        logic [NR*DW-1:0] saved;
        int               cyc;
        got_idx.delete();
        got_dat.delete();
        n_done      = 0;
        n_busy_post = 0;
        lat         = 0;
        m_diff      = diff;
        @(negedge clk);
        start     = 1'b1;
        diff_mode = diff;
        out_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            m_prev[i] = m_snap[i];
            m_snap[i] = rf[i*DW +: DW];
        end
        saved = rf;
        pv    = 1'b0;
        pr    = 1'b1;
        pidx  = '0;
        pdat  = '0;
        cyc   = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            cyc++;
            start     = 1'b0;
            diff_mode = 1'b0;
            if (mid && k == 5) begin
                start = 1'b1;
                rf    = ~rf;
            end
            out_ready = bp ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
            if (pv && !pr) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_idx", out_idx, pidx);
                chk("stall_data", out_data, pdat);
            end
            if (abort_n > 0 && got_idx.size() == abort_n) begin
                rst       = 1'b1;
                out_ready = 1'b0;
                @(negedge clk);
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_emit", emit_count, 0);
                chk("abort_done", done, 0);
                rst = 1'b0;
                for (int i = 0; i < NR; i++) begin
                    m_snap[i] = '0;
                    m_prev[i] = '0;
                end
                return;
            end
            if (out_valid && out_ready) begin
                got_idx.push_back(int'(out_idx));
                got_dat.push_back(out_data);
            end
            pv   = out_valid;
            pr   = out_ready;
            pidx = out_idx;
            pdat = out_data;
            if (done) begin
                n_done++;
                lat = cyc;
                break;
            end
        end
        if (mid) begin
            rf = saved;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                ec_after = emit_count;
            end
            if (done) begin
                n_done++;
            end
            if (busy) begin
                n_busy_post++;
            end
        end
    endtask

    // Compare captured transfers against the snapshot model.
    task automatic check_list(input string tag);
        int exp_idx [$];
        for (int i = 1; i < NR; i++) begin
            if (!m_diff || m_snap[i] != m_prev[i]) begin
                exp_idx.push_back(i);
            end
        end
        chk({tag, "_n"}, got_idx.size(), exp_idx.size());
        for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
            chk({tag, "_idx"}, got_idx[j], exp_idx[j]);
            chk({tag, "_dat"}, got_dat[j], m_snap[exp_idx[j]]);
        end
        chk({tag, "_ec"}, ec_after, exp_idx.size());
    endtask

    initial begin
        int cyc;
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        diff_mode = 1'b0;
        out_ready = 1'b0;
        start8    = 1'b0;
        diff8     = 1'b0;
        ready8    = 1'b1;
        rf        = '0;
        for (int i = 0; i < NR; i++) begin
            set_reg(i, DW'(i * 32'h1111_1111));
            m_snap[i] = '0;
            m_prev[i] = '0;
        end
        for (int i = 0; i < 8; i++) begin
            rf8[i*16 +: 16] = 16'h0A00 + 16'(i);
        end
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ec", emit_count, 0);
        rst = 1'b0;

        // Small build: idx 0..7, 10 cycles inclusive.
        @(negedge clk);
        start8 = 1'b1;
        cyc    = 1;
        n      = 0;
        lat    = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            cyc++;
            start8 = 1'b0;
            if (valid8 && ready8) begin
                chk("d8_idx", idx8, n);
                chk("d8_data", data8, 16'h0A00 + 16'(n));
                n++;
            end
            if (done8) begin
                lat = cyc;
                break;
            end
        end
        chk("d8_lat", lat, 10);
        chk("d8_n", n, 8);
        @(negedge clk);
        chk("d8_ec", ec8, 8);

        // Full dump.
        run_dump(1'b0, 1'b0, 0, 1'b0);
        check_list("full");
        chk("full_lat", lat, 33);
        chk("full_cnt", got_idx.size(), 31);
        if (got_idx.size() > 4) begin
            chk("full_x5_idx", got_idx[4], 5);
            chk("full_x5_dat", got_dat[4], 32'h5555_5555);
        end
        chk("full_ec", ec_after, 31);

        // Diff dump with two changes.
        set_reg(3, 32'hDEAD_BEEF);
        set_reg(31, 32'h0000_0001);
        run_dump(1'b1, 1'b0, 0, 1'b0);
        check_list("diff");
        chk("diff_n", got_idx.size(), 2);
        if (got_idx.size() == 2) begin
            chk("diff_i0", got_idx[0], 3);
            chk("diff_d0", got_dat[0], 32'hDEAD_BEEF);
            chk("diff_i1", got_idx[1], 31);
            chk("diff_d1", got_dat[1], 32'h0000_0001);
        end
        chk("diff_ec", ec_after, 2);
        chk("diff_lat", lat, 33);

        // Diff dump with nothing changed.
        run_dump(1'b1, 1'b0, 0, 1'b0);
        chk("diff0_n", got_idx.size(), 0);
        chk("diff0_ec", ec_after, 0);
        chk("diff0_lat", lat, 33);

        // Backpressure.
        run_dump(1'b0, 1'b1, 0, 1'b0);
        check_list("bp");
        chk("bp_cnt", got_idx.size(), 31);

        // Ignored start and snapshot isolation.
        run_dump(1'b0, 1'b0, 0, 1'b1);
        check_list("mid");
        chk("mid_done", n_done, 1);
        chk("mid_busy", n_busy_post, 0);
        chk("mid_lat", lat, 33);

        // Reset after 10 transfers, then diff against cleared prev.
        run_dump(1'b0, 1'b0, 10, 1'b0);
        chk("abort_ndone", n_done, 0);
        run_dump(1'b1, 1'b0, 0, 1'b0);
        check_list("post");
        chk("post_cnt", got_idx.size(), 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
